// File: rtl/chacha_stream_xor.sv
// chacha_stream_xor
// Sequencing stage around a combinational ChaCha20 block core. The upstream side
// builds the 512-bit block input from the constants, the latched key, the block
// counter and the nonce. The downstream side captures the keystream one block at a
// time and XORs it word-serially onto a valid/ready stream, so the same block
// serves for encryption and decryption.
// Optional feature macro: CHACHA_BLK_CNT_EN adds the blk_cnt output, a saturating
// count of keystream blocks generated since the last start.

module chacha_stream_xor #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [255:0]      key,
    input  logic [95:0]       nonce,
    input  logic [31:0]       ctr_init,
    input  logic              abort,
    output logic              busy,
    output logic              ctr_wrap,
    output logic [511:0]      blk_state,
    input  logic [511:0]      blk_ks,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
`ifdef CHACHA_BLK_CNT_EN
    ,
    output logic [31:0]       blk_cnt
`endif
);

    localparam int BEATS = 512 / DATA_W;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    // "expand 32-byte k" in the word order the core expects
    localparam logic [127:0] SIGMA = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_STREAM
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [255:0]       key_r;
    logic [95:0]        nonce_r;
    logic [31:0]        ctr_r;
    logic [511:0]       ks_buf;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  ks_word;

    logic start_go;
    logic gen_go;
    logic xfer;
    logic blk_end;
    logic wrap_hit;
    logic ctr_step;

    // The block core sees only registered values, so its input is stable for the GEN cycle
    assign blk_state = {SIGMA, key_r, ctr_r, nonce_r};

    assign busy = (state != ST_IDLE);

    // abort blocks acceptance in the same cycle so the offered beat is not consumed
    assign s_ready = (state == ST_STREAM) && !abort && (!m_valid || m_ready);

    assign start_go = (state == ST_IDLE) && start && !abort;
    assign gen_go   = (state == ST_GEN) && !abort;
    assign xfer     = s_valid && s_ready;
    assign blk_end  = xfer && !s_last && (idx == LAST_IDX);
    assign wrap_hit = blk_end && (ctr_r == 32'hFFFF_FFFF);
    assign ctr_step = blk_end && !wrap_hit;

    // Select the keystream slice for the current beat, word 0 at the top of the buffer
    always_comb begin
        ks_word = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (idx == IDX_W'(i)) begin
                ks_word = ks_buf[511 - i*DATA_W -: DATA_W];
            end
        end
    end

    // Next-state decode; abort overrides everything, including start
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_GEN;
                    end
                end
                ST_GEN: begin
                    state_nxt = ST_STREAM;
                end
                ST_STREAM: begin
                    if (xfer && s_last) begin
                        state_nxt = ST_IDLE;
                    end else if (wrap_hit) begin
                        state_nxt = ST_IDLE;
                    end else if (ctr_step) begin
                        state_nxt = ST_GEN;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Message parameters: latched on start, counter advances once per completed block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_r   <= '0;
            nonce_r <= '0;
            ctr_r   <= '0;
        end else if (start_go) begin
            key_r   <= key;
            nonce_r <= nonce;
            ctr_r   <= ctr_init;
        end else if (ctr_step) begin
            ctr_r   <= ctr_r + 32'd1;
        end
    end

    // Keystream capture in GEN and beat index within the current block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_buf <= '0;
            idx    <= '0;
        end else if (gen_go) begin
            ks_buf <= blk_ks;
            idx    <= '0;
        end else if (xfer) begin
            idx    <= idx + IDX_W'(1);
        end
    end

    // Output register: a new beat loads on transfer, otherwise it drains on m_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (abort) begin
            m_valid <= 1'b0;
        end else if (xfer) begin
            m_valid <= 1'b1;
            m_data  <= s_data ^ ks_word;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Sticky counter-exhausted flag, cleared only by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_wrap <= 1'b0;
        end else if (start_go) begin
            ctr_wrap <= 1'b0;
        end else if (wrap_hit && !abort) begin
            ctr_wrap <= 1'b1;
        end
    end

`ifdef CHACHA_BLK_CNT_EN
    // Saturating count of GEN cycles since the last start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (start_go) begin
            blk_cnt <= '0;
        end else if (gen_go && (blk_cnt != 32'hFFFF_FFFF)) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_chacha_stream_xor.sv
// tb_chacha_stream_xor
// Directed bench for chacha_stream_xor. A behavioural ChaCha20 block function stands
// in for the combinational core; expected stream words come from RFC 8439 constants
// or from the same behavioural function applied to bench-built block inputs.

module tb_chacha_stream_xor;

    localparam int DATA_W = 32;
    localparam logic [127:0] SIGMA = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

    localparam logic [255:0] RFC_KEY = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
    localparam logic [95:0]  RFC_NONCE = {32'h09000000, 32'h4a000000, 32'h00000000};
    localparam logic [255:0] K2 = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_deadbeefcafef00d;
    localparam logic [95:0]  N2 = 96'h11223344_55667788_99aabbcc;
    localparam logic [255:0] K3 = 256'hffeeddccbbaa9988_7766554433221100_0f0f0f0ff0f0f0f0_1357924680acebdf;
    localparam logic [95:0]  N3 = 96'h00000001_00000002_00000003;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [255:0]      key;
    logic [95:0]       nonce;
    logic [31:0]       ctr_init;
    logic              abort;
    logic              busy;
    logic              ctr_wrap;
    logic [511:0]      blk_state;
    logic [511:0]      blk_ks;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
`ifdef CHACHA_BLK_CNT_EN
    logic [31:0]       blk_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] out_data[$];
    logic              out_last[$];
    int                acc_cyc[$];
    int                accepted;
    logic              busy_after_last;
    logic [31:0]       rfc_ks[16];

    always #5 clk = ~clk;

    chacha_stream_xor #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .nonce     (nonce),
        .ctr_init  (ctr_init),
        .abort     (abort),
        .busy      (busy),
        .ctr_wrap  (ctr_wrap),
        .blk_state (blk_state),
        .blk_ks    (blk_ks),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
`ifdef CHACHA_BLK_CNT_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                        input logic [31:0] c_i, input logic [31:0] d_i);
        logic [31:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha_block(input logic [511:0] st);
        logic [31:0]  x[16];
        logic [31:0]  s[16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) begin
            s[i] = st[511 - 32*i -: 32];
            x[i] = s[i];
        end
        for (int rnd = 0; rnd < 10; rnd++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[511 - 32*i -: 32] = x[i] + s[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] ks_word(input logic [255:0] k, input logic [95:0] n,
                                            input logic [31:0] c, input int w);
        logic [511:0] b;
        b = chacha_block({SIGMA, k, c, n});
        return b[511 - 32*w -: 32];
    endfunction

    function automatic logic [31:0] data_for(input int i);
        return 32'(i + 1) * 32'h9E3779B9 ^ 32'h0F1E2D3C;
    endfunction

    // Behavioural stand-in for the combinational block core
    assign blk_ks = chacha_block(blk_state);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkWide(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic startMsg(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        start    = 1'b1;
        key      = k;
        nonce    = n;
        ctr_init = c;
        tick();
        start    = 1'b0;
    endtask

    // Drives one message and records every accepted input and delivered output beat
    task automatic applyStimulus(input int n_beats, input int last_beat, input bit zero_data,
                                 input bit toggle_ready, input int abort_beat);
        int                cyc;
        bit                stall_prev;
        logic [DATA_W-1:0] stall_data;
        bit                did_abort;
        bit                done;
        bit                last_now;
        bit                abort_now;
        out_data.delete();
        out_last.delete();
        acc_cyc.delete();
        accepted        = 0;
        busy_after_last = 1'b1;
        cyc             = 0;
        stall_prev      = 0;
        stall_data      = '0;
        did_abort       = 0;
        done            = 0;
        while (!done && cyc < 400) begin
            abort_now = (abort_beat > 0) && !did_abort && (accepted == abort_beat - 1);
            abort     = abort_now;
            s_valid   = (accepted < n_beats);
            s_data    = zero_data ? '0 : data_for(accepted);
            s_last    = (accepted + 1 == last_beat);
            m_ready   = toggle_ready ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (stall_prev) begin
                checkBit("hold_valid", m_valid, 1'b1);
                checkOutput("hold_data", m_data, stall_data);
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            if (m_valid && m_ready) begin
                out_data.push_back(m_data);
                out_last.push_back(m_last);
            end
            last_now = 0;
            if (abort_now) begin
                checkBit("abort_s_ready", s_ready, 1'b0);
            end else if (s_valid && s_ready) begin
                accepted++;
                acc_cyc.push_back(cyc);
                last_now = s_last;
            end
            tick();
            cyc++;
            if (last_now) begin
                busy_after_last = busy;
            end
            if (abort_now) begin
                did_abort = 1;
                abort     = 1'b0;
                checkBit("abort_m_valid", m_valid, 1'b0);
                checkBit("abort_busy", busy, 1'b0);
            end
            if (!busy && !m_valid) begin
                done = 1;
            end
        end
        abort = 1'b0;
        checkBit("stream_done", done, 1'b1);
    endtask

    task automatic checkBeats(input string tag, input int n, input bit zero_data,
                              input logic [255:0] k, input logic [95:0] nn, input logic [31:0] c0);
        logic [31:0] exp_w;
        for (int i = 0; i < n; i++) begin
            exp_w = (zero_data ? 32'h0 : data_for(i)) ^ ks_word(k, nn, c0 + 32'(i / 16), i % 16);
            checkOutput(tag, out_data[i], exp_w);
        end
    endtask

    task automatic checkRfc(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput(tag, out_data[i], rfc_ks[i]);
        end
    endtask

    initial begin
        rfc_ks = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                   32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                   32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                   32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
        rst_n    = 1'b0;
        start    = 1'b0;
        key      = '0;
        nonce    = '0;
        ctr_init = '0;
        abort    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        m_ready  = 1'b0;

        // Reset state
        #12;
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_ctr_wrap", ctr_wrap, 1'b0);
        checkBit("rst_m_valid", m_valid, 1'b0);
        checkOutput("rst_m_data", m_data, 32'h0);
        checkBit("rst_m_last", m_last, 1'b0);
        checkBit("rst_s_ready", s_ready, 1'b0);
        checkWide("rst_blk_state", blk_state, {SIGMA, 384'h0});
`ifdef CHACHA_BLK_CNT_EN
        checkOutput("rst_blk_cnt", blk_cnt, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Test 1: RFC 8439 keystream block
        $display("[TB] test 1: RFC 8439 block");
        startMsg(RFC_KEY, RFC_NONCE, 32'd1);
        checkWide("t1_blk_state", blk_state, {SIGMA, RFC_KEY, 32'd1, RFC_NONCE});
        checkBit("t1_gen_busy", busy, 1'b1);
        checkBit("t1_gen_s_ready", s_ready, 1'b0);
        applyStimulus(16, 16, 1'b1, 1'b0, 0);
        s_valid = 1'b0;
        checkOutput("t1_count", out_data.size(), 32'd16);
        checkRfc("t1_data", 16);
        checkBit("t1_last", out_last[15], 1'b1);
        checkBit("t1_busy_end", busy, 1'b0);

        // Test 2: three blocks, 40 beats
        $display("[TB] test 2: multi-block");
        startMsg(K2, N2, 32'd1);
        applyStimulus(40, 40, 1'b0, 1'b0, 0);
        s_valid = 1'b0;
        checkOutput("t2_count", out_data.size(), 32'd40);
        checkBeats("t2_data", 40, 1'b0, K2, N2, 32'd1);
        checkOutput("t2_gap_mid", acc_cyc[20] - acc_cyc[19], 32'd1);
        checkOutput("t2_gap16", acc_cyc[16] - acc_cyc[15], 32'd2);
        checkOutput("t2_gap32", acc_cyc[32] - acc_cyc[31], 32'd2);
        checkBit("t2_last40", out_last[39], 1'b1);
        checkBit("t2_last39", out_last[38], 1'b0);
        checkBit("t2_busy_after_last", busy_after_last, 1'b0);
`ifdef CHACHA_BLK_CNT_EN
        checkOutput("t2_blk_cnt", blk_cnt, 32'd3);
`endif

        // Test 3: downstream backpressure
        $display("[TB] test 3: backpressure");
        startMsg(K3, N3, 32'd7);
        applyStimulus(20, 20, 1'b0, 1'b1, 0);
        s_valid = 1'b0;
        checkOutput("t3_count", out_data.size(), 32'd20);
        checkBeats("t3_data", 20, 1'b0, K3, N3, 32'd7);
        checkBit("t3_last", out_last[19], 1'b1);

        // Test 4: counter exhaustion
        $display("[TB] test 4: counter wrap");
        startMsg(K2, N2, 32'hFFFF_FFFF);
        applyStimulus(20, 20, 1'b0, 1'b0, 0);
        checkOutput("t4_accepted", accepted, 32'd16);
        checkOutput("t4_count", out_data.size(), 32'd16);
        checkBeats("t4_data", 16, 1'b0, K2, N2, 32'hFFFF_FFFF);
        checkBit("t4_ctr_wrap", ctr_wrap, 1'b1);
        checkBit("t4_busy", busy, 1'b0);
        #1;
        checkBit("t4_s_ready", s_ready, 1'b0);
        s_valid = 1'b0;
        tick();
        checkBit("t4_wrap_sticky", ctr_wrap, 1'b1);

        // Test 5: abort on beat 5, then restart from word 0
        $display("[TB] test 5: abort");
        startMsg(RFC_KEY, RFC_NONCE, 32'd1);
        checkBit("t5_wrap_cleared", ctr_wrap, 1'b0);
        applyStimulus(16, 16, 1'b1, 1'b0, 5);
        s_valid = 1'b0;
        checkOutput("t5_accepted", accepted, 32'd4);
        checkOutput("t5_count", out_data.size(), 32'd4);
        checkRfc("t5_data", 4);
        startMsg(RFC_KEY, RFC_NONCE, 32'd1);
        applyStimulus(16, 16, 1'b1, 1'b0, 0);
        s_valid = 1'b0;
        checkOutput("t5_restart_count", out_data.size(), 32'd16);
        checkRfc("t5_restart_data", 16);

        // Test 6: asynchronous reset in the middle of a block
        $display("[TB] test 6: async reset");
        startMsg(K3, N3, 32'd5);
        s_valid = 1'b1;
        s_data  = data_for(0);
        s_last  = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        tick();
        checkBit("t6_pre_m_valid", m_valid, 1'b1);
        checkBit("t6_pre_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkBit("t6_busy", busy, 1'b0);
        checkBit("t6_m_valid", m_valid, 1'b0);
        checkOutput("t6_m_data", m_data, 32'h0);
        checkBit("t6_m_last", m_last, 1'b0);
        checkBit("t6_ctr_wrap", ctr_wrap, 1'b0);
        checkBit("t6_s_ready", s_ready, 1'b0);
        checkWide("t6_blk_state", blk_state, {SIGMA, 384'h0});
`ifdef CHACHA_BLK_CNT_EN
        checkOutput("t6_blk_cnt", blk_cnt, 32'h0);
`endif
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
